pushbutton_edge_port: RTL and testbench



---
 rtl/pushbutton_edge_port_pkg.sv | 15 +
 rtl/debounce_bit.sv | 43 ++++
 rtl/pushbutton_edge_port.sv | 77 +++++++
 tb/tb_pushbutton_edge_port.sv | 129 ++++++++++++
 4 files changed

// File: rtl/pushbutton_edge_port_pkg.sv
// Shared constants and helpers for the pushbutton edge-capture port.
package pushbutton_edge_port_pkg;
  localparam logic [1:0] OFS_DATA = 2'd0;
  localparam logic [1:0] OFS_RSVD = 2'd1;
  localparam logic [1:0] OFS_MASK = 2'd2;
  localparam logic [1:0] OFS_EDGE = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchroniser followed by a hold-time debouncer for one button.
module debounce_bit
  import pushbutton_edge_port_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic stable_o
);
  localparam int CW = clog2(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised level disagrees with stable.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) stable_d = sync2_q;
      else                                   cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
endmodule

// File: rtl/pushbutton_edge_port.sv
// Avalon-MM pushbutton port: debounced levels, sticky rising-edge capture, masked irq.
module pushbutton_edge_port
  import pushbutton_edge_port_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] buttons_in
);
  logic [WIDTH-1:0] stable, stable_prev_q;
  logic [WIDTH-1:0] mask_q, mask_d, edge_q, edge_d, rise, clr;
  logic [31:0]      rd_q, rd_d;
  logic             irq_q, irq_d;
  logic             wr, rd;
  logic             unused_wd;

  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk      (clk),
      .reset    (reset),
      .din_i    (buttons_in[i]),
      .stable_o (stable[i])
    );
  end

  assign wr        = chipselect & write;
  assign rd        = chipselect & read;
  assign unused_wd = ^writedata;

  always_comb begin
    mask_d = mask_q;
    if (wr && address == OFS_MASK) mask_d = writedata[WIDTH-1:0];
    clr    = (wr && address == OFS_EDGE) ? writedata[WIDTH-1:0] : '0;
    rise   = stable & ~stable_prev_q;
    // OR-ing the new rise after the clear makes a same-cycle press survive.
    edge_d = (edge_q & ~clr) | rise;
    irq_d  = |(edge_q & mask_q);
    rd_d   = rd_q;
    if (rd) begin
      rd_d = '0;
      case (address)
        OFS_DATA: rd_d[WIDTH-1:0] = stable;
        OFS_MASK: rd_d[WIDTH-1:0] = mask_q;
        OFS_EDGE: rd_d[WIDTH-1:0] = edge_q;
        default:  rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_prev_q <= '0;
      mask_q        <= '0;
      edge_q        <= '0;
      rd_q          <= '0;
      irq_q         <= 1'b0;
    end else begin
      stable_prev_q <= stable;
      mask_q        <= mask_d;
      edge_q        <= edge_d;
      rd_q          <= rd_d;
      irq_q         <= irq_d;
    end
  end

  assign readdata = rd_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_pushbutton_edge_port.sv
// Scoreboarded bench for pushbutton_edge_port with WIDTH=2, DEBOUNCE_CYCLES=4.
module tb_pushbutton_edge_port;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0, read = 1'b0, write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [1:0]  buttons_in = 2'b11;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  pushbutton_edge_port #(.WIDTH(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata),
    .irq(irq), .buttons_in(buttons_in)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0; writedata = '0;
  endtask

  task automatic bus_rd(input logic [1:0] a, input logic [31:0] e, input string tag);
    logic [31:0] x;
    exp_q.push_back(e);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick();
    chipselect = 1'b0; read = 1'b0;
    x = exp_q.pop_front();
    chk(tag, readdata, x);
  endtask

  initial begin
    // reset with both buttons pressed
    tick(3);
    chk("rst_rdata", readdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0; buttons_in = 2'b00;
    bus_rd(2'd0, 32'h0, "post_rst_data");
    bus_rd(2'd2, 32'h0, "post_rst_mask");
    bus_rd(2'd3, 32'h0, "post_rst_edge");

    // 3-cycle glitch must not reach stable
    buttons_in = 2'b01; tick(3); buttons_in = 2'b00; tick(8);
    bus_rd(2'd0, 32'h0, "glitch_data");
    bus_rd(2'd3, 32'h0, "glitch_edge");

    bus_wr(2'd2, 32'h1);
    bus_rd(2'd2, 32'h1, "mask_rb");

    // held press: stable visible on the 7th back-to-back read
    buttons_in = 2'b01;
    for (int i = 0; i < 7; i++) bus_rd(2'd0, (i == 6) ? 32'h1 : 32'h0, "press_lat");
    chk("irq_pre", {31'b0, irq}, 32'h0);
    tick();
    chk("irq_set", {31'b0, irq}, 32'h1);
    bus_rd(2'd3, 32'h1, "edge0");

    // clear edge: irq drops one edge after the clear
    bus_wr(2'd3, 32'h1);
    chk("irq_clr_n", {31'b0, irq}, 32'h1);
    tick();
    chk("irq_clr_n1", {31'b0, irq}, 32'h0);
    bus_rd(2'd3, 32'h0, "edge_clr");

    // unmasked button 1
    buttons_in = 2'b11; tick(8);
    chk("irq_unmasked", {31'b0, irq}, 32'h0);
    bus_rd(2'd3, 32'h2, "edge1");
    bus_wr(2'd3, 32'h2);

    // falling edge ignored
    buttons_in = 2'b10; tick(8);
    bus_rd(2'd3, 32'h0, "fall_ign");

    // clear write on the very edge that captures the rise
    buttons_in = 2'b11; tick(6);
    bus_wr(2'd3, 32'h1);
    chk("coll_irq_n", {31'b0, irq}, 32'h0);
    tick();
    chk("coll_irq", {31'b0, irq}, 32'h1);
    bus_rd(2'd3, 32'h1, "coll_edge");

    // register file behaviour
    bus_wr(2'd2, 32'hFFFF_FFFF);
    bus_rd(2'd2, 32'h3, "mask_wide");
    bus_wr(2'd1, 32'hFFFF_FFFF);
    bus_rd(2'd1, 32'h0, "rsvd");
    bus_wr(2'd0, 32'h0);
    bus_rd(2'd0, 32'h3, "data_ro");
    buttons_in = 2'b00; tick(8);
    bus_rd(2'd3, 32'h1, "release_edge");
    bus_rd(2'd0, 32'h0, "release_data");
    chk("release_irq", {31'b0, irq}, 32'h1);

    // reset 2 cycles into a press, with a read in flight
    buttons_in = 2'b01; tick(2);
    reset = 1'b1;
    bus_rd(2'd3, 32'h0, "rst_inflight");
    chk("rst_mid_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) bus_rd(2'd3, (i == 7) ? 32'h1 : 32'h0, "rst_mid_edge");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
